// File: rtl/gametank_pad_pkg.sv
// Shared constants and byte-format helpers for the GameTank controller port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gametank_pad_pkg;

    // Default register offsets of the two pad ports within the controller page
    localparam logic [3:0] REG_PAD1_DEF = 4'h8;
    localparam logic [3:0] REG_PAD2_DEF = 4'h9;

    // Bit positions inside the 12-bit button word {R L X A RT LT DN UP START SELECT Y B}
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DN     = 5;
    localparam int BTN_LT     = 6;
    localparam int BTN_RT     = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Value the bus sees when nothing is pressed or no pad is attached
    localparam logic [7:0] DOUT_IDLE = 8'hFF;

    // First byte of a two-byte pad read: d-pad, face B/Y, select/start (active-low)
    function automatic logic [7:0] phase0_byte(input logic [11:0] b);
        return ~{b[BTN_UP], b[BTN_DN], b[BTN_LT], b[BTN_RT],
                 b[BTN_B],  b[BTN_Y],  b[BTN_SELECT], b[BTN_START]};
    endfunction

    // Second byte: A/X/shoulders in the high nibble, low nibble reads all ones
    function automatic logic [7:0] phase1_byte(input logic [11:0] b);
        return ~{b[BTN_A], b[BTN_X], b[BTN_L], b[BTN_R], 4'b0000};
    endfunction

endpackage

// File: rtl/gametank_pad_phase.sv
// One pad port: phase bit, button snapshot and phase-0/phase-1 byte mux.
// Latency: byte_o is combinational from sel/snapshot/buttons; state updates on the read edge.
// Backpressure: none; every read pulse is consumed in the cycle it arrives.
module gametank_pad_phase
    import gametank_pad_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] btn_i,
    input  logic        rd_self_i,
    input  logic        rd_other_i,
    output logic [7:0]  byte_o
);

    logic        sel_q;
    logic [11:0] snap_q;

    // Phase 0 reads the same (registered) buttons that get snapshotted, so the
    // two bytes of one pad read always describe a single instant.
    always_comb begin
        byte_o = sel_q ? phase1_byte(snap_q) : phase0_byte(btn_i);
    end

    // Own read toggles the phase (capturing on phase 0); a read of the other port resyncs us to phase 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q  <= 1'b0;
            snap_q <= 12'h000;
        end else if (rd_self_i) begin
            sel_q <= ~sel_q;
            if (!sel_q) begin
                snap_q <= btn_i;
            end
        end else if (rd_other_i) begin
            sel_q <= 1'b0;
        end
    end

endmodule

// File: rtl/gametank_pad_port.sv
// GameTank two-port controller register: strobe edge detect, address decode, dout.
// Latency: inputs registered once; dout loads one cycle after the read-strobe rising edge.
// Backpressure: none; a held strobe yields a single read, extra cycles are ignored.
module gametank_pad_port
    import gametank_pad_pkg::*;
#(
    parameter logic [3:0] REG_PAD1 = REG_PAD1_DEF,
    parameter logic [3:0] REG_PAD2 = REG_PAD2_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cs,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [11:0] pad1_buttons,
    input  logic [11:0] pad2_buttons,
    input  logic        pad1_present,
    input  logic        pad2_present,
    output logic [7:0]  dout
);

    logic [11:0] pad1_btn_q;
    logic [11:0] pad2_btn_q;
    logic        pad1_prs_q;
    logic        pad2_prs_q;
    logic        strb_q;
    logic [7:0]  dout_q;

    logic        strb;
    logic        rd_evt;
    logic        hit1;
    logic        hit2;
    logic [7:0]  byte1;
    logic [7:0]  byte2;
    logic [7:0]  dout_d;

    // Single input stage: pad pins are asynchronous to the CPU bus
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pad1_btn_q <= 12'h000;
            pad2_btn_q <= 12'h000;
            pad1_prs_q <= 1'b0;
            pad2_prs_q <= 1'b0;
        end else begin
            pad1_btn_q <= pad1_buttons;
            pad2_btn_q <= pad2_buttons;
            pad1_prs_q <= pad1_present;
            pad2_prs_q <= pad2_present;
        end
    end

    // Strobe history resets high so a strobe already asserted at reset release is not a read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            strb_q <= 1'b1;
        end else begin
            strb_q <= strb;
        end
    end

    // Rising edge of the qualified strobe, decoded against the two pad offsets
    always_comb begin
        strb   = cs & rd;
        rd_evt = strb & ~strb_q;
        hit1   = rd_evt && (addr == REG_PAD1);
        hit2   = rd_evt && (addr == REG_PAD2);
    end

    gametank_pad_phase u_pad1 (
        .clk        (clk),
        .resetn     (resetn),
        .btn_i      (pad1_btn_q),
        .rd_self_i  (hit1),
        .rd_other_i (hit2),
        .byte_o     (byte1)
    );

    gametank_pad_phase u_pad2 (
        .clk        (clk),
        .resetn     (resetn),
        .btn_i      (pad2_btn_q),
        .rd_self_i  (hit2),
        .rd_other_i (hit1),
        .byte_o     (byte2)
    );

    // Next read data: an absent pad reads idle, other offsets leave dout untouched
    always_comb begin
        dout_d = dout_q;
        if (hit1) begin
            dout_d = pad1_prs_q ? byte1 : DOUT_IDLE;
        end else if (hit2) begin
            dout_d = pad2_prs_q ? byte2 : DOUT_IDLE;
        end
    end

    // Read data register, held between read events
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q <= DOUT_IDLE;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_gametank_pad_port.sv
// Self-checking bench for gametank_pad_port: directed scenarios plus random reads.
// Latency: expects dout one cycle after each strobe rising edge.
// Backpressure: n/a.
module tb_gametank_pad_port;

    localparam logic [3:0] A_PAD1 = 4'h8;
    localparam logic [3:0] A_PAD2 = 4'h9;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cs;
    logic        rd;
    logic [3:0]  addr;
    logic [11:0] pad1_buttons;
    logic [11:0] pad2_buttons;
    logic        pad1_present;
    logic        pad2_present;
    logic [7:0]  dout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the CPU would see from a real GameTank pad port
    logic [11:0] m_btn [2];
    logic        m_prs [2];
    logic [11:0] m_snap [2];
    int          m_phase [2];
    logic [7:0]  m_dout;

    always #5 clk = ~clk;

    gametank_pad_port #(
        .REG_PAD1 (A_PAD1),
        .REG_PAD2 (A_PAD2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cs           (cs),
        .rd           (rd),
        .addr         (addr),
        .pad1_buttons (pad1_buttons),
        .pad2_buttons (pad2_buttons),
        .pad1_present (pad1_present),
        .pad2_present (pad2_present),
        .dout         (dout)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: dout=%02h expected=%02h", tag, got, exp);
        end
    endtask

    // Byte 0: buttons UP,DN,LT,RT,B,Y,SELECT,START from msb to lsb, pressed reads 0
    function automatic logic [7:0] ref_p0(input logic [11:0] b);
        int idx [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = ~b[idx[k]];
        return r;
    endfunction

    // Byte 1: A,X,L,R in the high nibble, low nibble always 1
    function automatic logic [7:0] ref_p1(input logic [11:0] b);
        int idx [4] = '{8, 9, 10, 11};
        logic [7:0] r;
        r = 8'hFF;
        for (int k = 0; k < 4; k++) r[7-k] = ~b[idx[k]];
        return r;
    endfunction

    task automatic model_reset();
        m_phase[0] = 0;  m_phase[1] = 0;
        m_snap[0]  = '0; m_snap[1]  = '0;
        m_dout     = 8'hFF;
    endtask

    task automatic model_read(input logic [3:0] a);
        int p;
        if (a == A_PAD1) p = 0;
        else if (a == A_PAD2) p = 1;
        else return;
        if (m_phase[p] == 0) begin
            m_snap[p] = m_btn[p];
            m_dout    = m_prs[p] ? ref_p0(m_btn[p]) : 8'hFF;
        end else begin
            m_dout    = m_prs[p] ? ref_p1(m_snap[p]) : 8'hFF;
        end
        m_phase[p]   = 1 - m_phase[p];
        m_phase[1-p] = 0;
    endtask

    // Change pad pins and give the input stage a cycle to capture them
    task automatic set_pads(input logic [11:0] b1, input logic [11:0] b2,
                            input logic p1, input logic p2);
        pad1_buttons = b1; pad2_buttons = b2;
        pad1_present = p1; pad2_present = p2;
        m_btn[0] = b1; m_btn[1] = b2;
        m_prs[0] = p1; m_prs[1] = p2;
        @(negedge clk);
    endtask

    // One CPU read with a strobe held for len cycles
    task automatic do_read(input logic [3:0] a, input int len, input string tag);
        model_read(a);
        addr = a; cs = 1'b1; rd = 1'b1;
        @(negedge clk);
        check({tag, "_lat"}, dout, m_dout);
        repeat (len - 1) @(negedge clk);
        check({tag, "_hold"}, dout, m_dout);
        rd = 1'b0; cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic held);
        resetn = 1'b0; cs = held; rd = held;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_active", dout, 8'hFF);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_release", dout, m_dout);
        cs = 1'b0; rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] a;
        resetn = 1'b0; cs = 1'b0; rd = 1'b0; addr = 4'h0;
        m_btn[0] = '0; m_btn[1] = '0; m_prs[0] = 1'b0; m_prs[1] = 1'b0;
        set_pads(12'h000, 12'h000, 1'b1, 1'b1);
        model_reset();

        // Strobe held across reset release must not count as a read
        apply_reset(1'b1);

        // START then A: phase-1 byte comes from the snapshot, not live pins
        set_pads(12'h008, 12'h000, 1'b1, 1'b1);
        do_read(A_PAD1, 1, "p1_r1");
        set_pads(12'h100, 12'h000, 1'b1, 1'b1);
        do_read(A_PAD1, 2, "p1_r2");
        do_read(A_PAD1, 1, "p1_r3");
        do_read(A_PAD1, 3, "p1_r4");

        // Reading pad 2 resyncs pad 1 to phase 0
        set_pads(12'h008, 12'h000, 1'b1, 1'b1);
        do_read(A_PAD1, 1, "x_r1");
        do_read(A_PAD2, 1, "x_r2");
        do_read(A_PAD1, 1, "x_r3");

        // Absent pad 2 reads idle but still toggles its phase
        set_pads(12'h008, 12'h0FF, 1'b1, 1'b0);
        do_read(A_PAD2, 1, "abs_r1");
        do_read(A_PAD2, 1, "abs_r2");
        set_pads(12'h008, 12'h008, 1'b1, 1'b1);
        do_read(A_PAD2, 1, "abs_r3");

        // Long strobe gives one event; a read at an unrelated offset changes nothing
        set_pads(12'h108, 12'h000, 1'b1, 1'b1);
        do_read(A_PAD1, 1, "sync_r0");
        do_read(A_PAD2, 1, "sync_r1");
        do_read(A_PAD1, 5, "long_r1");
        do_read(4'h3, 2, "other_r");
        do_read(A_PAD1, 1, "long_r2");

        // Rising rd without cs is not a read
        cs = 1'b0; rd = 1'b1; addr = A_PAD1;
        repeat (2) @(negedge clk);
        rd = 1'b0; @(negedge clk);
        check("nocs", dout, m_dout);

        // Reset in the middle of a two-byte read restarts at phase 0
        do_read(A_PAD1, 1, "mid_r1");
        apply_reset(1'b1);
        do_read(A_PAD1, 1, "mid_r2");

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            set_pads(12'($urandom), 12'($urandom),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            case ($urandom_range(0, 4))
                0, 1:    a = A_PAD1;
                2, 3:    a = A_PAD2;
                default: a = 4'($urandom);
            endcase
            do_read(a, $urandom_range(1, 4), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gametank_pad_port.md
GAMETANK_PAD_PORT -- requirements
Module: gametank_pad_port

Interface
REQ-001 SHALL have parameter REG_PAD1, default 4'h8, giving the register offset of pad port 1.
REQ-002 SHALL have parameter REG_PAD2, default 4'h9, giving the register offset of pad port 2.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cs, input, 1 bit: controller-register page select from the bus decoder.
REQ-006 SHALL have port rd, input, 1 bit: CPU read strobe, level-sensitive, may span multiple cycles.
REQ-007 SHALL have port addr, input, 4 bits: register offset within the page.
REQ-008 SHALL have port pad1_buttons, input, 12 bits: active-high buttons {R L X A RT LT DN UP START SELECT Y B}, bit 11 = R.
REQ-009 SHALL have port pad2_buttons, input, 12 bits: same format as pad1_buttons.
REQ-010 SHALL have port pad1_present, input, 1 bit: high when a controller is attached to port 1.
REQ-011 SHALL have port pad2_present, input, 1 bit: high when a controller is attached to port 2.
REQ-012 SHALL have port dout, output, 8 bits: active-low read data returned to the CPU.

Function
REQ-013 SHALL register pad*_buttons and pad*_present in one input stage; all later logic uses only the registered values.
REQ-014 SHALL detect a read event on the cycle where (cs & rd) is high and was low the previous cycle; addr is sampled on that cycle.
REQ-015 SHALL ignore a held strobe: at most one read event per rising edge of (cs & rd).
REQ-016 SHALL keep one phase bit, sel1 and sel2, per port.
REQ-017 On a port read event with that port's sel = 0, SHALL capture the registered buttons into that port's snapshot and return phase-0 data from the same values.
REQ-018 Phase-0 byte SHALL be ~{UP, DN, LT, RT, B, Y, SELECT, START}.
REQ-019 Phase-1 byte SHALL be ~{A, X, L, R, 4'b0000}, so the low nibble reads 4'hF; it is taken from the snapshot, never from live inputs.
REQ-020 A read event at REG_PAD1 SHALL toggle sel1 and clear sel2.
REQ-021 A read event at REG_PAD2 SHALL toggle sel2 and clear sel1.
REQ-022 If the addressed port's present bit is low, SHALL return 8'hFF; the sel toggling and clearing still apply.
REQ-023 SHALL load dout on the cycle after the read event (latency 1) and hold it until the next read event.
REQ-024 A read event at any other addr SHALL change no state, including dout.
REQ-025 Button changes between phase-0 and phase-1 reads SHALL NOT affect the phase-1 byte.

Reset
REQ-026 On resetn low, SHALL asynchronously set sel1 = sel2 = 0, dout = 8'hFF, both snapshots = 12'h000, input registers = 0.
REQ-027 On resetn low, SHALL set the strobe-history flop to 1, so a strobe held high across reset release produces no read event.
REQ-028 A read in progress during reset SHALL be abandoned; the first read after release returns phase 0.

Structure
REQ-029 Package gametank_pad_pkg SHALL hold REG_PAD1/REG_PAD2 defaults, the button bit-index constants (BTN_B=0 … BTN_R=11) and the phase-0/phase-1 byte-format functions.
REQ-030 SHALL instantiate sub-module gametank_pad_phase twice, one per port; it contains that port's snapshot, sel bit and byte mux; the top holds edge detection, decode and dout.

Verification
REQ-031 Reset, then rd held high with cs=1 across release -> no event; dout = 8'hFF, sel1 = 0.
REQ-032 pad1 = 12'h008 (START), present=1, read REG_PAD1 -> dout = 8'hFE one cycle after the edge; then change to 12'h100 (A) and read again -> 8'hFF (snapshot had no A).
REQ-033 Continue REQ-032 with A held: 3rd read -> 8'hFF (new snapshot, phase 0); 4th read -> 8'h7F.
REQ-034 Read REG_PAD1 once (sel1 = 1), then read REG_PAD2 -> sel1 = 0; next REG_PAD1 read returns phase 0.
REQ-035 pad2_present = 0, read REG_PAD2 twice -> 8'hFF both reads; sel2 toggles 0->1->0.
REQ-036 5-cycle strobe at addr 4'h8, then a strobe at addr 4'h3 -> exactly one event, and dout unchanged after the 4'h3 read.
